imm_gen_pipe: RTL

Pipelined, parametrised successor to the combinational immediate generator, sitting between instruction fetch/decode and the execute stage. It accepts an instruction plus an immediate-type select over a valid/ready handshake and extracts the sign-extended immediate for all five RV32 formats (I, S, B, U, J) at any DATA_WIDTH ≥ 32. It returns the result one cycle later through a registered output with a skid buffer, so it sustains full throughput under back-pressure. It also keeps a saturating count of illegal type selects for debug.

---
 rtl/imm_gen_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// RV32 immediate generator with a valid/ready handshake, a registered output and a one-entry skid buffer.
// A saturating counter records how many illegal format selects were accepted.
module imm_gen_pipe #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TAG_WIDTH   = 4,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [2:0]             in_imm_type,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_imm,
  output logic                   out_illegal,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic [CNT_WIDTH-1:0]   illegal_cnt,
  input  logic                   clr_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (INSTR_WIDTH != 32) begin : g_bad_instr_width
    $error("imm_gen_pipe: INSTR_WIDTH must be 32");
  end
  if (DATA_WIDTH < 32) begin : g_bad_data_width
    $error("imm_gen_pipe: DATA_WIDTH must be at least 32");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [31:0]            imm32_c;
  logic [DATA_WIDTH-1:0]  imm_c;
  logic                   illegal_c;
  logic                   accept_c;
  logic                   load_out_c;
  logic                   load_skid_c;
  logic                   skid_to_out_c;

  logic [DATA_WIDTH-1:0]  skid_imm;
  logic                   skid_illegal;
  logic [TAG_WIDTH-1:0]   skid_tag;

  // Opcode bits are never part of an immediate.
  logic                   unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  // Format extraction on the 32-bit view; the wide result is a sign extension of it.
  always_comb begin
    imm32_c   = '0;
    illegal_c = 1'b0;
    case (in_imm_type)
      3'b000:  imm32_c = {{20{in_instr[31]}}, in_instr[31:20]};
      3'b001:  imm32_c = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b010:  imm32_c = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      3'b011:  imm32_c = {in_instr[31:12], 12'b0};
      3'b100:  imm32_c = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: illegal_c = 1'b1;
    endcase
  end

  assign imm_c    = DATA_WIDTH'($signed(imm32_c));
  assign accept_c = in_valid && in_ready;

  // Next state and which register gets loaded this cycle.
  always_comb begin
    state_nxt     = state;
    load_out_c    = 1'b0;
    load_skid_c   = 1'b0;
    skid_to_out_c = 1'b0;
    case (state)
      EMPTY: begin
        if (accept_c) begin
          state_nxt  = ONE;
          load_out_c = 1'b1;
        end
      end
      ONE: begin
        if (accept_c && !out_ready) begin
          state_nxt   = FULL;
          load_skid_c = 1'b1;
        end else if (accept_c) begin
          load_out_c = 1'b1;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_nxt     = ONE;
          skid_to_out_c = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready and out_valid are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_imm      <= '0;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      skid_imm     <= '0;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
    end else begin
      if (load_out_c) begin
        out_imm     <= imm_c;
        out_illegal <= illegal_c;
        out_tag     <= in_tag;
      end else if (skid_to_out_c) begin
        out_imm     <= skid_imm;
        out_illegal <= skid_illegal;
        out_tag     <= skid_tag;
      end
      if (load_skid_c) begin
        skid_imm     <= imm_c;
        skid_illegal <= illegal_c;
        skid_tag     <= in_tag;
      end
    end
  end

  // Counts on acceptance; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (clr_cnt) begin
      illegal_cnt <= '0;
    end else if (accept_c && illegal_c && (illegal_cnt != CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
